// File: rtl/memory_cycle_pkg.sv
// memory_cycle_pkg: shared widths, pipeline-register layouts and bubble encodings for the MEM stage.
package memory_cycle_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OFS_W  = 2;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              zero;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] add_result;
        logic [DATA_W-1:0] write_data;
        logic [REG_W-1:0]  des_reg;
    } ex_mem_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_res;
        logic [REG_W-1:0]  des_reg;
    } mem_wb_t;

    localparam ex_mem_t EX_MEM_BUBBLE = '0;
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

    function automatic logic is_misaligned(input ex_mem_t m);
        return (m.mem_read || m.mem_write) && (m.alu_res[OFS_W-1:0] != '0);
    endfunction
endpackage

// File: rtl/memory_cycle_data_memory.sv
// data_memory: word-addressed data RAM with synchronous write and combinational read.
module data_memory
    import memory_cycle_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];
endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: MIPS MEM stage -- EX/MEM register, data memory access, branch/jump redirect, MEM/WB register.
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              RegWriteE,
    input  logic              MemToRegE,
    input  logic              MemReadE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic              zeroE,
    input  logic [DATA_W-1:0] ALUresE,
    input  logic [DATA_W-1:0] AddresultE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [REG_W-1:0]  des_RegisterE,
    output logic              PCSrcM,
    output logic [DATA_W-1:0] TargetM,
    output logic              misalignM,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUresW,
    output logic [REG_W-1:0]  des_RegisterW
);
    ex_mem_t           r_m;
    ex_mem_t           w_e;
    mem_wb_t           r_w;
    logic              w_misalign;
    logic              w_we;
    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_rdata;

    assign w_e = '{reg_write: RegWriteE, mem_to_reg: MemToRegE, mem_read: MemReadE,
                   mem_write: MemWriteE, branch: BranchE, jump: JumpE, zero: zeroE,
                   alu_res: ALUresE, add_result: AddresultE, write_data: WriteDataE,
                   des_reg: des_RegisterE};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_m <= EX_MEM_BUBBLE;
        else if (flush)  r_m <= EX_MEM_BUBBLE;
        else if (!stall) r_m <= w_e;
    end

    assign w_misalign = is_misaligned(r_m);
    // Upper address bits are dropped so accesses wrap modulo DEPTH words.
    assign w_idx      = r_m.alu_res[ADDR_W+OFS_W-1:OFS_W];
    assign w_we       = r_m.mem_write && !stall && !w_misalign;

    data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dmem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_idx),
        .raddr (w_idx),
        .wdata (r_m.write_data),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_w <= MEM_WB_BUBBLE;
        else if (stall) r_w <= MEM_WB_BUBBLE;
        else            r_w <= '{reg_write: r_m.reg_write && !(r_m.mem_read && w_misalign),
                                 mem_to_reg: r_m.mem_to_reg,
                                 read_data: (r_m.mem_read && !w_misalign) ? w_rdata : '0,
                                 alu_res: r_m.alu_res, des_reg: r_m.des_reg};
    end

    assign PCSrcM        = (r_m.branch && r_m.zero) || r_m.jump;
    assign TargetM       = r_m.add_result;
    assign misalignM     = w_misalign;
    assign RegWriteW     = r_w.reg_write;
    assign MemToRegW     = r_w.mem_to_reg;
    assign ReadDataW     = r_w.read_data;
    assign ALUresW       = r_w.alu_res;
    assign des_RegisterW = r_w.des_reg;
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: directed scenario bench for the MEM stage with hand-computed expectations.
module tb_memory_cycle;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic        RegWriteE, MemToRegE, MemReadE, MemWriteE, BranchE, JumpE, zeroE;
    logic [31:0] ALUresE, AddresultE, WriteDataE;
    logic [4:0]  des_RegisterE;
    logic        PCSrcM, misalignM, RegWriteW, MemToRegW;
    logic [31:0] TargetM, ReadDataW, ALUresW;
    logic [4:0]  des_RegisterW;
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    memory_cycle dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemReadE(MemReadE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE), .zeroE(zeroE),
        .ALUresE(ALUresE), .AddresultE(AddresultE), .WriteDataE(WriteDataE),
        .des_RegisterE(des_RegisterE), .PCSrcM(PCSrcM), .TargetM(TargetM),
        .misalignM(misalignM), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .ReadDataW(ReadDataW), .ALUresW(ALUresW), .des_RegisterW(des_RegisterW)
    );

    task automatic drive(input logic rw, m2r, mr, mw, br, j, z,
                         input logic [31:0] alu, add, wd, input logic [4:0] rd);
        RegWriteE = rw; MemToRegE = m2r; MemReadE = mr; MemWriteE = mw;
        BranchE = br; JumpE = j; zeroE = z;
        ALUresE = alu; AddresultE = add; WriteDataE = wd; des_RegisterE = rd;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; nop();
        #3;
        vectors++;
        if (RegWriteW !== 1'b0 || ReadDataW !== 32'h0 || ALUresW !== 32'h0 || PCSrcM !== 1'b0) begin
            errors++; $display("FAIL reset_init: RegWriteW=%b ReadDataW=%h ALUresW=%h PCSrcM=%b, want all 0", RegWriteW, ReadDataW, ALUresW, PCSrcM);
        end
        tick(); rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 0, 32'h11, 32'h80, 32'h0, 5'd6);
        tick(); nop(); tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (RegWriteW !== 1'b0 || ALUresW !== 32'h0 || des_RegisterW !== 5'd0 || PCSrcM !== 1'b0 || TargetM !== 32'h0) begin
            errors++; $display("FAIL reset_mid: RegWriteW=%b ALUresW=%h des=%0d PCSrcM=%b TargetM=%h, want all 0", RegWriteW, ALUresW, des_RegisterW, PCSrcM, TargetM);
        end
        tick(); rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 32'h55, 32'h0, 32'h0, 5'd3);
        tick(); nop();
        vectors++;
        if (RegWriteW !== 1'b0) begin
            errors++; $display("FAIL reset_first_edge: RegWriteW=%b, want 0", RegWriteW);
        end
        tick();
        vectors++;
        if (RegWriteW !== 1'b1 || ALUresW !== 32'h55 || des_RegisterW !== 5'd3) begin
            errors++; $display("FAIL reset_second_edge: RegWriteW=%b ALUresW=%h des=%0d, want 1 00000055 3", RegWriteW, ALUresW, des_RegisterW);
        end
    endtask

    task automatic test_store_load();
        drive(0, 0, 0, 1, 0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 5'd0);
        tick();
        drive(1, 1, 1, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd5);
        tick(); nop();
        vectors++;
        if (RegWriteW !== 1'b0 || ALUresW !== 32'h10) begin
            errors++; $display("FAIL store_wb: RegWriteW=%b ALUresW=%h, want 0 00000010", RegWriteW, ALUresW);
        end
        tick();
        vectors++;
        if (ReadDataW !== 32'hDEADBEEF || MemToRegW !== 1'b1 || RegWriteW !== 1'b1 || des_RegisterW !== 5'd5) begin
            errors++; $display("FAIL store_load: ReadDataW=%h MemToRegW=%b RegWriteW=%b des=%0d, want deadbeef 1 1 5", ReadDataW, MemToRegW, RegWriteW, des_RegisterW);
        end
    endtask

    task automatic test_branch();
        drive(0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h40, 32'h0, 5'd0);
        tick();
        vectors++;
        if (PCSrcM !== 1'b1 || TargetM !== 32'h40) begin
            errors++; $display("FAIL branch_taken: PCSrcM=%b TargetM=%h, want 1 00000040", PCSrcM, TargetM);
        end
        drive(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h80, 32'h0, 5'd0);
        tick();
        vectors++;
        if (PCSrcM !== 1'b0 || TargetM !== 32'h80) begin
            errors++; $display("FAIL branch_not_taken: PCSrcM=%b TargetM=%h, want 0 00000080", PCSrcM, TargetM);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h100, 32'h0, 5'd0);
        tick(); nop();
        vectors++;
        if (PCSrcM !== 1'b1 || TargetM !== 32'h100) begin
            errors++; $display("FAIL jump: PCSrcM=%b TargetM=%h, want 1 00000100", PCSrcM, TargetM);
        end
        tick();
        vectors++;
        if (PCSrcM !== 1'b0) begin
            errors++; $display("FAIL redirect_one_cycle: PCSrcM=%b, want 0", PCSrcM);
        end
    endtask

    task automatic test_flush();
        drive(0, 0, 0, 1, 0, 0, 0, 32'h20, 32'h0, 32'h11111111, 5'd0);
        tick(); nop(); tick();
        drive(1, 0, 0, 1, 0, 0, 0, 32'h20, 32'h0, 32'h22222222, 5'd8);
        flush = 1'b1;
        tick(); flush = 1'b0;
        drive(1, 1, 1, 0, 0, 0, 0, 32'h20, 32'h0, 32'h0, 5'd7);
        tick(); nop();
        vectors++;
        if (RegWriteW !== 1'b0 || des_RegisterW !== 5'd0) begin
            errors++; $display("FAIL flush_bubble: RegWriteW=%b des=%0d, want 0 0", RegWriteW, des_RegisterW);
        end
        tick();
        vectors++;
        if (ReadDataW !== 32'h11111111 || RegWriteW !== 1'b1 || des_RegisterW !== 5'd7) begin
            errors++; $display("FAIL flush_no_store: ReadDataW=%h RegWriteW=%b des=%0d, want 11111111 1 7", ReadDataW, RegWriteW, des_RegisterW);
        end
    endtask

    task automatic test_stall();
        drive(1, 0, 0, 1, 0, 0, 0, 32'h30, 32'h0, 32'hCAFE0001, 5'd9);
        tick();
        stall = 1'b1;
        drive(1, 1, 1, 0, 0, 0, 0, 32'h30, 32'h0, 32'h0, 5'd10);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (RegWriteW !== 1'b0 || ALUresW !== 32'h0 || des_RegisterW !== 5'd0) begin
                errors++; $display("FAIL stall_bubble[%0d]: RegWriteW=%b ALUresW=%h des=%0d, want 0 0 0", i, RegWriteW, ALUresW, des_RegisterW);
            end
        end
        stall = 1'b0;
        tick(); nop();
        vectors++;
        if (RegWriteW !== 1'b1 || ALUresW !== 32'h30 || des_RegisterW !== 5'd9) begin
            errors++; $display("FAIL stall_release: RegWriteW=%b ALUresW=%h des=%0d, want 1 00000030 9", RegWriteW, ALUresW, des_RegisterW);
        end
        tick();
        vectors++;
        if (ReadDataW !== 32'hCAFE0001 || des_RegisterW !== 5'd10) begin
            errors++; $display("FAIL stall_store: ReadDataW=%h des=%0d, want cafe0001 10", ReadDataW, des_RegisterW);
        end
    endtask

    task automatic test_misalign_wrap();
        drive(1, 1, 1, 0, 0, 0, 0, 32'h13, 32'h0, 32'h0, 5'd4);
        tick(); nop();
        vectors++;
        if (misalignM !== 1'b1) begin
            errors++; $display("FAIL misalign_flag: misalignM=%b, want 1", misalignM);
        end
        tick();
        vectors++;
        if (ReadDataW !== 32'h0 || RegWriteW !== 1'b0 || misalignM !== 1'b0) begin
            errors++; $display("FAIL misalign_load: ReadDataW=%h RegWriteW=%b misalignM=%b, want 0 0 0", ReadDataW, RegWriteW, misalignM);
        end
        drive(0, 0, 0, 1, 0, 0, 0, 32'h11, 32'h0, 32'h0, 5'd0);
        tick();
        drive(1, 1, 1, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd1);
        tick(); nop(); tick();
        vectors++;
        if (ReadDataW !== 32'hDEADBEEF) begin
            errors++; $display("FAIL misalign_store: ReadDataW=%h, want deadbeef", ReadDataW);
        end
        drive(0, 0, 0, 1, 0, 0, 0, 32'h400, 32'h0, 32'h12345678, 5'd0);
        tick();
        drive(1, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd2);
        tick(); nop(); tick();
        vectors++;
        if (ReadDataW !== 32'h12345678 || RegWriteW !== 1'b1) begin
            errors++; $display("FAIL wrap: ReadDataW=%h RegWriteW=%b, want 12345678 1", ReadDataW, RegWriteW);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_branch();
        test_flush();
        test_stall();
        test_misalign_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
